// File: rtl/tx_framer_pkg.sv
// Shared types and defaults for the parametrised serial frame transmitter.
// Also used by the receive side for the CRC defaults.
package tx_framer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_HDR,
        ST_DATA,
        ST_CRC,
        ST_GAP
    } state_t;

    localparam logic [7:0] DEF_SFD           = 8'b10101011;
    localparam int         DEF_PREAMBLE_BITS = 16;
    localparam int         DEF_CRC_W         = 8;
    localparam logic [7:0] DEF_CRC_POLY      = 8'h07;
    localparam logic [7:0] DEF_CRC_INIT      = 8'h00;

    // Payload byte count for a length field, clamped to the payload buffer size.
    function automatic int frame_bytes(input int len, input int max_bytes);
        return (len + 1 > max_bytes) ? max_bytes : len + 1;
    endfunction

endpackage

// File: rtl/crc_serial_param.sv
// Bit-serial MSB-first CRC, non-reflected, no final XOR.
// clear has priority over enable so a new frame always starts from the seed.
module crc_serial_param
    import tx_framer_pkg::*;
#(
    parameter int               CRC_W    = DEF_CRC_W,
    parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(DEF_CRC_POLY),
    parameter logic [CRC_W-1:0] CRC_INIT = CRC_W'(DEF_CRC_INIT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             data_in,
    output logic [CRC_W-1:0] crc_out
);

    logic [CRC_W-1:0] crc_reg;
    logic             fb;

    assign fb      = crc_reg[CRC_W-1] ^ data_in;
    assign crc_out = crc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_reg <= CRC_INIT;
        end else if (clear) begin
            crc_reg <= CRC_INIT;
        end else if (enable) begin
            crc_reg <= {crc_reg[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
        end
    end

endmodule

// File: rtl/tx_framer_param.sv
// Serial frame transmitter: preamble, SFD, header, payload, CRC, then an idle gap.
// Every output is registered; tx_line is loaded with the bit belonging to the next state.
module tx_framer_param
    import tx_framer_pkg::*;
#(
    parameter int               MAX_BYTES     = 16,
    parameter int               LEN_W         = 4,
    parameter int               HDR_W         = 8,
    parameter int               PREAMBLE_BITS = DEF_PREAMBLE_BITS,
    parameter logic [7:0]       SFD           = DEF_SFD,
    parameter int               CRC_W         = DEF_CRC_W,
    parameter logic [CRC_W-1:0] CRC_POLY      = CRC_W'(DEF_CRC_POLY),
    parameter logic [CRC_W-1:0] CRC_INIT      = CRC_W'(DEF_CRC_INIT),
    parameter int               IFG_BITS      = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           tx_valid,
    output logic                           tx_ready,
    input  logic [HDR_W-1:0]               tx_header,
    input  logic [MAX_BYTES*8-1:0]         tx_data,
    input  logic                           err_inject,
    input  logic [$clog2(MAX_BYTES*8)-1:0] err_bit_idx,
    output logic                           tx_line,
    output logic                           tx_busy,
    output logic                           tx_done,
    output logic [15:0]                    frame_cnt
);

    localparam int CNT_W = 16;
    localparam int IDX_W = $clog2(MAX_BYTES*8);
    localparam int SH_W  = 8 + HDR_W + MAX_BYTES*8;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [SH_W-1:0]    sh_reg;
    logic [CRC_W-1:0]   crc_sh_reg;
    logic [CNT_W-1:0]   nbits_reg;
    logic               inj_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               line_reg, line_next;
    logic               busy_reg, ready_reg, done_reg;
    logic [15:0]        frame_cnt_reg;
    logic               handshake, frame_end, shift_en, crc_en, flip;
    logic [CRC_W-1:0]   crc_out;

    assign handshake = (state_reg == ST_IDLE) && tx_valid;
    assign tx_ready  = ready_reg;
    assign tx_line   = line_reg;
    assign tx_busy   = busy_reg;
    assign tx_done   = done_reg;
    assign frame_cnt = frame_cnt_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + 1'b1;
        frame_end  = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (tx_valid) state_next = ST_PRE;
            end
            ST_PRE: if (cnt_reg == CNT_W'(PREAMBLE_BITS-1)) begin
                state_next = ST_SFD;
                cnt_next   = '0;
            end
            ST_SFD: if (cnt_reg == CNT_W'(7)) begin
                state_next = ST_HDR;
                cnt_next   = '0;
            end
            ST_HDR: if (cnt_reg == CNT_W'(HDR_W-1)) begin
                state_next = ST_DATA;
                cnt_next   = '0;
            end
            ST_DATA: if (cnt_reg == nbits_reg - 1'b1) begin
                state_next = ST_CRC;
                cnt_next   = '0;
            end
            ST_CRC: if (cnt_reg == CNT_W'(CRC_W-1)) begin
                state_next = (IFG_BITS == 0) ? ST_IDLE : ST_GAP;
                cnt_next   = '0;
                frame_end  = 1'b1;
            end
            ST_GAP: if (cnt_reg == CNT_W'(IFG_BITS-1)) begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // SFD, header and payload sit back to back in one shift register; the CRC sees the true bit.
    always_comb begin
        shift_en  = (state_next == ST_SFD) || (state_next == ST_HDR) || (state_next == ST_DATA);
        crc_en    = (state_next == ST_DATA);
        flip      = inj_reg && (cnt_next == CNT_W'(idx_reg));
        line_next = 1'b0;
        case (state_next)
            ST_PRE:  line_next = ~cnt_next[0];
            ST_SFD,
            ST_HDR:  line_next = sh_reg[SH_W-1];
            ST_DATA: line_next = sh_reg[SH_W-1] ^ flip;
            ST_CRC:  line_next = (state_reg == ST_CRC) ? crc_sh_reg[CRC_W-1] : crc_out[CRC_W-1];
            default: line_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            sh_reg        <= '0;
            crc_sh_reg    <= '0;
            nbits_reg     <= '0;
            inj_reg       <= 1'b0;
            idx_reg       <= '0;
            line_reg      <= 1'b0;
            busy_reg      <= 1'b0;
            ready_reg     <= 1'b1;
            done_reg      <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            line_reg  <= line_next;
            busy_reg  <= (state_next != ST_IDLE);
            ready_reg <= (state_next == ST_IDLE);
            done_reg  <= frame_end;
            if (frame_end) frame_cnt_reg <= frame_cnt_reg + 16'd1;
            if (handshake) begin
                sh_reg    <= {SFD, tx_header, tx_data};
                nbits_reg <= CNT_W'(frame_bytes(int'(tx_header[LEN_W-1:0]), MAX_BYTES) * 8);
                inj_reg   <= err_inject;
                idx_reg   <= err_bit_idx;
            end else if (shift_en) begin
                sh_reg <= {sh_reg[SH_W-2:0], 1'b0};
            end
            if (state_next == ST_CRC) begin
                crc_sh_reg <= (state_reg == ST_CRC) ? {crc_sh_reg[CRC_W-2:0], 1'b0}
                                                    : {crc_out[CRC_W-2:0], 1'b0};
            end
        end
    end

    crc_serial_param #(
        .CRC_W    (CRC_W),
        .CRC_POLY (CRC_POLY),
        .CRC_INIT (CRC_INIT)
    ) u_crc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (handshake),
        .enable  (crc_en),
        .data_in (sh_reg[SH_W-1]),
        .crc_out (crc_out)
    );

endmodule

// File: tb/tb_tx_framer_param.sv
// Directed bench for tx_framer_param: captures tx_line per cycle and checks every field
// against hand-computed values (CRC-8/SMBUS: 0x01->0x07, 0x02->0x0E, "123456789"->0xF4).
module tb_tx_framer_param;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic [7:0]   tx_header = '0;
    logic [127:0] tx_data = '0;
    logic         err_inject = 1'b0;
    logic [6:0]   err_bit_idx = '0;
    logic         tx_line, tx_busy, tx_done;
    logic [15:0]  frame_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    bit cap_line [512];
    bit cap_busy [512];
    bit cap_done [512];
    bit cap_ready[512];

    always #5 clk = ~clk;

    tx_framer_param dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_header   (tx_header),
        .tx_data     (tx_data),
        .err_inject  (err_inject),
        .err_bit_idx (err_bit_idx),
        .tx_line     (tx_line),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .frame_cnt   (frame_cnt)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] get_bits(input int start, input int n);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r = {r[126:0], cap_line[start+i]};
        return r;
    endfunction

    // Present a frame and return #1 after the handshake edge; the next negedge is the first preamble bit.
    task automatic send(input logic [7:0] hdr, input logic [127:0] data, input logic inj,
                        input logic [6:0] idx, input bit hold);
        int w;
        @(negedge clk);
        tx_header   = hdr;
        tx_data     = data;
        err_inject  = inj;
        err_bit_idx = idx;
        tx_valid    = 1'b1;
        w = 0;
        while (!tx_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        check_val("handshake_ready", tx_ready, 1'b1);
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic capture(input int n, input bit scramble, input int drop_at);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_line[i]  = tx_line;
            cap_busy[i]  = tx_busy;
            cap_done[i]  = tx_done;
            cap_ready[i] = tx_ready;
            if (scramble && (i == 3 || i == 30 || i == 36)) begin
                tx_header   = 8'hFF;
                tx_data     = {$urandom, $urandom, $urandom, $urandom};
                err_inject  = 1'b1;
                err_bit_idx = 7'd0;
            end
            if (i == drop_at) tx_valid = 1'b0;
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] hdr, input logic [127:0] exp_data,
                               input int nbytes, input logic [7:0] exp_crc, input logic [15:0] exp_fcnt);
        int f, done_idx, done_n, busy_n;
        f = 40 + nbytes*8;
        done_idx = -1;
        done_n = 0;
        busy_n = 0;
        for (int i = 0; i < f + 10; i++) begin
            if (cap_done[i] && done_idx < 0) done_idx = i;
            if (cap_done[i]) done_n++;
            if (cap_busy[i]) busy_n++;
        end
        check_val({tag, "_preamble"}, get_bits(0, 16), 128'hAAAA);
        check_val({tag, "_sfd"}, get_bits(16, 8), 128'hAB);
        check_val({tag, "_header"}, get_bits(24, 8), 128'(hdr));
        check_val({tag, "_data"}, get_bits(32, nbytes*8), exp_data);
        check_val({tag, "_crc"}, get_bits(f - 8, 8), 128'(exp_crc));
        check_val({tag, "_gap_zero"}, get_bits(f, 8), 128'h0);
        check_val({tag, "_done_idx"}, 128'(done_idx), 128'(f));
        check_val({tag, "_done_count"}, 128'(done_n), 128'd1);
        check_val({tag, "_busy_cycles"}, 128'(busy_n), 128'(f + 8));
        check_val({tag, "_frame_cnt"}, 128'(frame_cnt), 128'(exp_fcnt));
        $display("[TB] frame %s: %0d line bits, crc %02h, frame_cnt %0d", tag, f, get_bits(f - 8, 8), frame_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_n, done_n;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_tx_line", tx_line, 1'b0);
        check_val("rst_tx_busy", tx_busy, 1'b0);
        check_val("rst_tx_ready", tx_ready, 1'b1);
        check_val("rst_tx_done", tx_done, 1'b0);
        check_val("rst_frame_cnt", frame_cnt, 16'd0);
        $display("[TB] reset state checked");
        rst_n = 1'b1;

        // Single-byte frame, CRC 0x07
        send(8'h10, {8'h01, 120'h0}, 1'b0, 7'd0, 1'b0);
        capture(58, 1'b0, -1);
        check_frame("l0", 8'h10, 128'h01, 1, 8'h07, 16'd1);

        // Nine-byte CRC-8/SMBUS check vector, 112-bit frame
        send(8'h08, {72'h313233343536373839, 56'h0}, 1'b0, 7'd0, 1'b0);
        capture(122, 1'b0, -1);
        check_frame("l8", 8'h08, 128'h313233343536373839, 9, 8'hF4, 16'd2);

        // Injection on the first payload bit; CRC stays on the true data
        send(8'h10, {8'h01, 120'h0}, 1'b1, 7'd0, 1'b0);
        capture(58, 1'b0, -1);
        check_frame("inj0", 8'h10, 128'h81, 1, 8'h07, 16'd3);

        // Out-of-range injection index leaves the line untouched
        send(8'h10, {8'h01, 120'h0}, 1'b1, 7'd8, 1'b0);
        capture(58, 1'b0, -1);
        check_frame("inj8", 8'h10, 128'h01, 1, 8'h07, 16'd4);

        // Back-to-back frames with tx_valid held high
        send(8'h10, {8'h01, 120'h0}, 1'b0, 7'd0, 1'b1);
        capture(115, 1'b0, 57);
        rdy_n = 0;
        done_n = 0;
        for (int i = 0; i < 113; i++) begin
            if (cap_ready[i]) rdy_n++;
            if (cap_done[i]) done_n++;
        end
        check_val("b2b_f1_crc", get_bits(40, 8), 128'h07);
        check_val("b2b_gap_idle_zero", get_bits(48, 9), 128'h0);
        check_val("b2b_ready_cycles", 128'(rdy_n), 128'd1);
        check_val("b2b_ready_idle_slot", 128'(cap_ready[56]), 128'd1);
        check_val("b2b_f2_preamble", get_bits(57, 16), 128'hAAAA);
        check_val("b2b_f2_data", get_bits(89, 8), 128'h01);
        check_val("b2b_f2_crc", get_bits(97, 8), 128'h07);
        check_val("b2b_done_count", 128'(done_n), 128'd2);
        check_val("b2b_frame_cnt", frame_cnt, 16'd6);
        $display("[TB] frame b2b: two frames, ready cycles %0d, frame_cnt %0d", rdy_n, frame_cnt);

        // Asynchronous reset in the middle of an all-ones payload
        send(8'h10, {8'hFF, 120'h0}, 1'b0, 7'd0, 1'b0);
        repeat (34) @(negedge clk);
        check_val("mid_data_line_high", tx_line, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_rst_tx_line", tx_line, 1'b0);
        check_val("async_rst_tx_busy", tx_busy, 1'b0);
        check_val("async_rst_tx_ready", tx_ready, 1'b1);
        check_val("async_rst_tx_done", tx_done, 1'b0);
        check_val("async_rst_frame_cnt", frame_cnt, 16'd0);
        $display("[TB] mid-frame reset checked");
        @(negedge clk);
        rst_n = 1'b1;

        send(8'h10, {8'h01, 120'h0}, 1'b0, 7'd0, 1'b0);
        capture(58, 1'b0, -1);
        check_frame("post_rst", 8'h10, 128'h01, 1, 8'h07, 16'd1);

        // Inputs disturbed during the frame must not alter it
        send(8'h10, {8'h02, 120'h0}, 1'b0, 7'd0, 1'b0);
        capture(58, 1'b1, -1);
        check_frame("latched", 8'h10, 128'h02, 1, 8'h0E, 16'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
